// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: parses E0/F0/E1 prefixes, tracks movement
// and fire keys, arbitrates left/right with last-pressed-wins.
module ps2_key_sequencer #(
   parameter int PREFIX_TIMEOUT = 50000,
   parameter int E1_SKIP_BYTES  = 7
) (
   input  logic       clk50m_i,
   input  logic       rst_i,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [1:0] movement_o,
   output logic       fire_o,
   output logic       key_event_o,
   output logic       seq_error_o
);

   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
   localparam int SW = (E1_SKIP_BYTES < 1) ? 1
                     : $clog2(E1_SKIP_BYTES + 1);

   localparam logic [TW-1:0] TO_LAST   = TW'(PREFIX_TIMEOUT - 1);
   localparam logic [SW-1:0] SKIP_INIT = SW'(E1_SKIP_BYTES);
   localparam logic [SW-1:0] SKIP_ONE  = SW'(1);

   localparam logic [7:0] B_E0 = 8'hE0;
   localparam logic [7:0] B_F0 = 8'hF0;
   localparam logic [7:0] B_E1 = 8'hE1;

   localparam logic [1:0] MV_NONE  = 2'b00;
   localparam logic [1:0] MV_LEFT  = 2'b01;
   localparam logic [1:0] MV_RIGHT = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXTBRK,
      SKIP
   } state_t;

   state_t        state, nxt_state;
   logic [TW-1:0] tcnt, nxt_tcnt;
   logic [SW-1:0] skip_cnt, nxt_skip;
   logic [2:0]    held, nxt_held;
   logic [1:0]    last_dir, nxt_last;
   logic [1:0]    nxt_move;
   logic          nxt_fire, nxt_evt, nxt_err;

   logic          do_make, do_break, is_ext, in_pfx, is_pfx_byte;
   logic [2:0]    hit;

   // one-hot key index: bit0 left, bit1 right, bit2 fire
   function automatic logic [2:0] key_map(
      input logic       ext,
      input logic [7:0] b
   );
      logic [2:0] k;
      k = 3'b000;
      if (ext) begin
         if (b == 8'h6B) k = 3'b001;
         else if (b == 8'h74) k = 3'b010;
      end else begin
         if (b == 8'h1C) k = 3'b001;
         else if (b == 8'h23) k = 3'b010;
         else if (b == 8'h29) k = 3'b100;
      end
      return k;
   endfunction

   assign in_pfx = (state == EXT) || (state == BRK)
                || (state == EXTBRK);

   assign is_pfx_byte = (received_data == B_E0)
                     || (received_data == B_F0)
                     || (received_data == B_E1);

   always_comb begin
      nxt_state = state;
      nxt_tcnt  = tcnt;
      nxt_skip  = skip_cnt;
      nxt_held  = held;
      nxt_last  = last_dir;
      nxt_move  = MV_NONE;
      nxt_fire  = 1'b0;
      nxt_evt   = 1'b0;
      nxt_err   = 1'b0;
      do_make   = 1'b0;
      do_break  = 1'b0;
      is_ext    = 1'b0;
      hit       = 3'b000;

      if (received_data_en) begin
         nxt_tcnt = '0;
         unique case (state)
            IDLE: begin
               if (received_data == B_E0) begin
                  nxt_state = EXT;
               end else if (received_data == B_F0) begin
                  nxt_state = BRK;
               end else if (received_data == B_E1) begin
                  if (E1_SKIP_BYTES > 0) begin
                     nxt_state = SKIP;
                     nxt_skip  = SKIP_INIT;
                  end
               end else begin
                  do_make = 1'b1;
               end
            end
            EXT: begin
               if (received_data == B_F0) begin
                  nxt_state = EXTBRK;
               end else if (is_pfx_byte) begin
                  nxt_err   = 1'b1;
                  nxt_state = IDLE;
               end else begin
                  do_make   = 1'b1;
                  is_ext    = 1'b1;
                  nxt_state = IDLE;
               end
            end
            BRK: begin
               nxt_state = IDLE;
               if (is_pfx_byte) nxt_err = 1'b1;
               else do_break = 1'b1;
            end
            EXTBRK: begin
               nxt_state = IDLE;
               is_ext    = 1'b1;
               if (is_pfx_byte) nxt_err = 1'b1;
               else do_break = 1'b1;
            end
            SKIP: begin
               if (skip_cnt <= SKIP_ONE) begin
                  nxt_skip  = '0;
                  nxt_state = IDLE;
               end else begin
                  nxt_skip = skip_cnt - SKIP_ONE;
               end
            end
            default: nxt_state = IDLE;
         endcase
      end else if (in_pfx) begin
         // a byte landing on the expiry cycle takes the branch above
         if (tcnt == TO_LAST) begin
            nxt_state = IDLE;
            nxt_tcnt  = '0;
            nxt_err   = 1'b1;
         end else begin
            nxt_tcnt = tcnt + TW'(1);
         end
      end

      hit = key_map(is_ext, received_data);

      if (do_make) begin
         nxt_held = held | hit;
         if (|(hit & ~held)) begin
            nxt_evt  = 1'b1;
            nxt_fire = hit[2];
            if (hit[0]) nxt_last = MV_LEFT;
            if (hit[1]) nxt_last = MV_RIGHT;
         end
      end

      if (do_break) begin
         nxt_held = held & ~hit;
         nxt_evt  = |(hit & held);
      end

      unique case (nxt_held[1:0])
         2'b11:   nxt_move = nxt_last;
         2'b01:   nxt_move = MV_LEFT;
         2'b10:   nxt_move = MV_RIGHT;
         default: nxt_move = MV_NONE;
      endcase
   end

   always_ff @(posedge clk50m_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         tcnt        <= '0;
         skip_cnt    <= '0;
         held        <= 3'b000;
         last_dir    <= MV_NONE;
         movement_o  <= MV_NONE;
         fire_o      <= 1'b0;
         key_event_o <= 1'b0;
         seq_error_o <= 1'b0;
      end else begin
         state       <= nxt_state;
         tcnt        <= nxt_tcnt;
         skip_cnt    <= nxt_skip;
         held        <= nxt_held;
         last_dir    <= nxt_last;
         movement_o  <= nxt_move;
         fire_o      <= nxt_fire;
         key_event_o <= nxt_evt;
         seq_error_o <= nxt_err;
      end
   end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed plus randomized bench for ps2_key_sequencer against a
// queue-based scan-code reference model.
module tb_ps2_key_sequencer;

   localparam int TO    = 32;
   localparam int SKIPN = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [7:0] data = 8'h00;
   logic [1:0] mv;
   logic       fire, evt, err;

   int total = 0;
   int bad   = 0;

   byte unsigned pfx[$];
   int           skip_left;
   int           gap;
   bit           held[3];
   int           last;
   logic [1:0]   e_mv;
   logic         e_fire, e_evt, e_err;

   ps2_key_sequencer #(
      .PREFIX_TIMEOUT(TO),
      .E1_SKIP_BYTES(SKIPN)
   ) dut (
      .clk50m_i(clk),
      .rst_i(rst),
      .received_data(data),
      .received_data_en(en),
      .movement_o(mv),
      .fire_o(fire),
      .key_event_o(evt),
      .seq_error_o(err)
   );

   always #10 clk = ~clk;

   function automatic int key_of(bit ext, byte unsigned b);
      if (ext) begin
         if (b == 8'h6B) return 0;
         if (b == 8'h74) return 1;
         return -1;
      end
      if (b == 8'h1C) return 0;
      if (b == 8'h23) return 1;
      if (b == 8'h29) return 2;
      return -1;
   endfunction

   task automatic model_reset();
      pfx.delete();
      skip_left = 0;
      gap       = 0;
      foreach (held[i]) held[i] = 0;
      last   = 0;
      e_mv   = 2'b00;
      e_fire = 0;
      e_evt  = 0;
      e_err  = 0;
   endtask

   task automatic apply(bit brk, bit ext, byte unsigned b);
      int k;
      k = key_of(ext, b);
      if (k < 0) return;
      if (!brk) begin
         if (!held[k]) begin
            e_evt = 1;
            if (k < 2) last = k;
            else e_fire = 1;
         end
         held[k] = 1;
      end else begin
         if (held[k]) e_evt = 1;
         held[k] = 0;
      end
   endtask

   task automatic model(bit v, byte unsigned b);
      bit ext, brk;
      e_fire = 0;
      e_evt  = 0;
      e_err  = 0;
      if (skip_left > 0) begin
         if (v) skip_left--;
      end else if (v) begin
         gap = 0;
         if (pfx.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
            else if (b == 8'hE1) skip_left = SKIPN;
            else apply(0, 0, b);
         end else if (pfx.size() == 1 && pfx[0] == 8'hE0
                      && b == 8'hF0) begin
            pfx.push_back(b);
         end else if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) begin
            e_err = 1;
            pfx.delete();
         end else begin
            ext = (pfx[0] == 8'hE0);
            brk = (pfx[pfx.size()-1] == 8'hF0);
            apply(brk, ext, b);
            pfx.delete();
         end
      end else if (pfx.size() > 0) begin
         gap++;
         if (gap == TO) begin
            e_err = 1;
            gap   = 0;
            pfx.delete();
         end
      end
      if (held[0] && held[1]) e_mv = (last == 0) ? 2'b01 : 2'b10;
      else if (held[0]) e_mv = 2'b01;
      else if (held[1]) e_mv = 2'b10;
      else e_mv = 2'b00;
   endtask

   task automatic check(input string tag);
      total++;
      assert (mv === e_mv) else begin
         bad++;
         $error("FAIL %s movement got=%b exp=%b", tag, mv, e_mv);
      end
      total++;
      assert (fire === e_fire) else begin
         bad++;
         $error("FAIL %s fire got=%b exp=%b", tag, fire, e_fire);
      end
      total++;
      assert (evt === e_evt) else begin
         bad++;
         $error("FAIL %s key_event got=%b exp=%b", tag, evt, e_evt);
      end
      total++;
      assert (err === e_err) else begin
         bad++;
         $error("FAIL %s seq_error got=%b exp=%b", tag, err, e_err);
      end
   endtask

   task automatic step(input bit v, input byte unsigned b,
                       input string tag);
      en   = v;
      data = v ? b : 8'($urandom);
      @(posedge clk);
      model(v, b);
      #1;
      check(tag);
      en = 1'b0;
   endtask

   task automatic send(input byte unsigned b, input string tag);
      step(1, b, tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 8'h00, tag);
   endtask

   task automatic do_reset(input string tag);
      #4;
      rst = 1'b1;
      #1;
      model_reset();
      check(tag);
      @(posedge clk);
      #1;
      check(tag);
      rst = 1'b0;
   endtask

   byte unsigned pal[10] = '{8'hE0, 8'hF0, 8'hE1, 8'h1C, 8'h23,
                             8'h29, 8'h6B, 8'h74, 8'h14, 8'h77};

   initial begin
      model_reset();
      #3;
      check("reset_async");
      @(posedge clk);
      #1;
      check("reset_hold");
      rst = 1'b0;
      idle(5, "idle");

      send(8'hE0, "left_e0");
      send(8'h6B, "left_make");
      idle(2, "left_hold");
      send(8'hE0, "left_brk_e0");
      send(8'hF0, "left_brk_f0");
      send(8'h6B, "left_brk");
      idle(2, "left_idle");

      send(8'h1C, "ovl_a");
      send(8'h23, "ovl_d");
      send(8'hF0, "ovl_f0");
      send(8'h23, "ovl_brk_d");
      send(8'hF0, "ovl_f0b");
      send(8'h1C, "ovl_brk_a");
      idle(2, "ovl_idle");

      send(8'h29, "fire1");
      send(8'h29, "fire_rep");
      send(8'h29, "fire_rep");
      send(8'hF0, "fire_f0");
      send(8'h29, "fire_brk");
      send(8'h29, "fire2");
      send(8'hF0, "fire_f0b");
      send(8'h29, "fire_brk2");

      send(8'hE0, "to_e0");
      idle(TO + 2, "to_wait");
      send(8'h74, "to_74");
      idle(2, "to_after");
      send(8'hE0, "to_edge_e0");
      idle(TO - 1, "to_edge_wait");
      send(8'h6B, "to_edge_byte");
      idle(2, "to_edge_after");
      send(8'hF0, "bf_f0");
      idle(TO, "bf_timeout");
      send(8'hE0, "ebt_e0");
      send(8'hF0, "ebt_f0");
      idle(TO + 1, "ebt_timeout");

      send(8'hF0, "mal_f0");
      send(8'hF0, "mal_f0f0");
      send(8'hE0, "mal_e0");
      send(8'hE1, "mal_e0e1");
      send(8'hE0, "mal_e0b");
      send(8'hE0, "mal_e0e0");
      send(8'hE0, "mal_ebk_e0");
      send(8'hF0, "mal_ebk_f0");
      send(8'hE0, "mal_ebk_e0b");
      send(8'hE0, "mal_ebk_e0c");
      send(8'hF0, "mal_ebk_f0c");
      send(8'hE1, "mal_ebk_e1");

      send(8'h1C, "pre_pause");
      send(8'hE1, "pause");
      send(8'h14, "pause");
      send(8'h77, "pause");
      send(8'hE1, "pause");
      send(8'hF0, "pause");
      send(8'h14, "pause");
      send(8'hF0, "pause");
      send(8'h77, "pause");
      send(8'h23, "post_pause_d");
      send(8'hF0, "post_f0");
      send(8'h1C, "post_brk_a");
      send(8'hF0, "post_f0b");
      send(8'h23, "post_brk_d");
      send(8'h1C, "post_a");

      send(8'hF0, "rst_mid_f0");
      do_reset("rst_mid");
      idle(1, "rst_after");
      send(8'h1C, "rst_make");
      idle(2, "rst_idle");

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 60) == 0)
            idle($urandom_range(TO - 2, TO + 2), "rnd_gap");
         else if ($urandom_range(0, 2) != 0)
            send(pal[$urandom_range(0, 9)], "rnd");
         else
            step(0, 8'h00, "rnd_idle");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
